// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ID/EX and EX/MEM word layouts, ALU codes, execute FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int IDEX_W  = 120;
  localparam int EXMEM_W = 75;

  // ALUOp encodings from the decode stage
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // load/store address
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;  // immediate add

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  // Multiplier step index whose completion ends the multiply
  localparam logic [4:0] MUL_LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // ID/EX word, MSB first: field positions are fixed by this ordering
  typedef struct packed {
    logic              reg_write;   // [119]
    logic              mem_to_reg;  // [118]
    logic              mem_write;   // [117]
    logic              mem_read;    // [116]
    logic [1:0]        alu_op;      // [115:114]
    logic              reg_dst;     // [113]
    logic              alu_src;     // [112]
    logic [5:0]        funct;       // [111:106]
    logic [REG_W-1:0]  rd;          // [105:101]
    logic [REG_W-1:0]  rt;          // [100:96]
    logic [DATA_W-1:0] imm;         // [95:64]
    logic [DATA_W-1:0] rd2;         // [63:32]
    logic [DATA_W-1:0] rd1;         // [31:0]
  } idex_t;

  // EX/MEM word, MSB first
  typedef struct packed {
    logic              reg_write;   // [74]
    logic              mem_write;   // [73]
    logic              mem_to_reg;  // [72]
    logic              mem_read;    // [71]
    logic [1:0]        rsvd;        // [70:69] always zero
    logic [REG_W-1:0]  wreg;        // [68:64]
    logic [DATA_W-1:0] wdata;       // [63:32]
    logic [DATA_W-1:0] result;      // [31:0]
  } exmem_t;

  // Controls of a multiply captured at issue, replayed when the product lands
  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } mul_ctrl_t;

  localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative 32-step shift-add multiplier, low 32 bits of the product.
// Latency: start edge loads operands, then 32 step edges; done_o high the cycle after the last step.
// Backpressure: none; caller must not pulse start_i while busy_o is high.
// Ports: clk, rst_n (sync, active-low), start_i, a_i/b_i operands,
//        busy_o, done_o, product_o (accumulator), count_o (current step index).
module seq_multiplier
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o,
  output logic [4:0]        count_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [4:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      // bits shifted past bit 31 cannot reach the low product word
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 5'd1;
      if (count_q == MUL_LAST_STEP) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = acc_q;
  assign count_o   = count_q;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU on the ID/EX word, registered EX/MEM word; mul via iterative multiplier.
// Latency: 1 clock for ALU ops; mul lands 34 edges after presentation (33 bubbles first).
// Backpressure: stall holds upstream while a mul is issued or in progress; downstream gets bubbles.
// Ports: clk, rst_n (sync, active-low), inValid, IDEXReg[119:0] in; stall, EXMEMReg[74:0] out.
module execute_stage
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  input  logic [IDEX_W-1:0]  IDEXReg,
  output logic               stall,
  output logic [EXMEM_W-1:0] EXMEMReg
);

  idex_t             idex;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              is_mul;
  logic [REG_W-1:0]  wreg;
  exmem_t            alu_word;

  ex_state_e         state_q, state_d;
  exmem_t            ex_mem_q, ex_mem_d;
  mul_ctrl_t         held_q, held_d;
  logic              mul_start;

  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [4:0]        mul_count;

  assign idex = IDEXReg;

  // ---------------- combinational ALU and field muxing ----------------
  always_comb begin
    op_b    = idex.alu_src ? idex.imm : idex.rd2;
    alu_res = '0;
    is_mul  = 1'b0;
    case (idex.alu_op)
      ALUOP_ADD, ALUOP_ADDI: alu_res = idex.rd1 + op_b;
      ALUOP_SUB:             alu_res = idex.rd1 - op_b;
      ALUOP_RTYPE: begin
        case (idex.funct)
          FUNCT_ADD: alu_res = idex.rd1 + op_b;
          FUNCT_SUB: alu_res = idex.rd1 - op_b;
          FUNCT_AND: alu_res = idex.rd1 & op_b;
          FUNCT_OR:  alu_res = idex.rd1 | op_b;
          FUNCT_NOR: alu_res = ~(idex.rd1 | op_b);
          FUNCT_SLT: alu_res = {31'd0, $signed(idex.rd1) < $signed(op_b)};
          FUNCT_MUL: is_mul  = 1'b1;
          default:   alu_res = '0;  // unknown funct: zero result, controls still pass
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign wreg = idex.reg_dst ? idex.rd : idex.rt;

  always_comb begin
    alu_word            = EXMEM_BUBBLE;
    alu_word.reg_write  = idex.reg_write;
    alu_word.mem_write  = idex.mem_write;
    alu_word.mem_to_reg = idex.mem_to_reg;
    alu_word.mem_read   = idex.mem_read;
    alu_word.wreg       = wreg;
    alu_word.wdata      = idex.rd2;
    alu_word.result     = alu_res;
  end

  // ---------------- multiplier ----------------
  seq_multiplier u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (mul_start),
    .a_i       (idex.rd1),
    .b_i       (idex.rd2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product),
    .count_o   (mul_count)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inValid && is_mul) state_d = ST_BUSY;
      ST_BUSY: if (mul_busy && (mul_count == MUL_LAST_STEP)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall     = 1'b0;
    mul_start = 1'b0;
    ex_mem_d  = EXMEM_BUBBLE;
    held_d    = held_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          if (is_mul) begin
            stall     = 1'b1;
            mul_start = 1'b1;
            held_d    = '{reg_write:  idex.reg_write,
                          mem_write:  idex.mem_write,
                          mem_to_reg: idex.mem_to_reg,
                          mem_read:   idex.mem_read,
                          wreg:       wreg,
                          wdata:      idex.rd2};
          end else begin
            ex_mem_d = alu_word;
          end
        end
      end
      ST_BUSY: stall = 1'b1;
      ST_DONE: begin
        // stall stays low here so upstream advances on the product edge
        if (mul_done) begin
          ex_mem_d = '{reg_write:  held_q.reg_write,
                       mem_write:  held_q.mem_write,
                       mem_to_reg: held_q.mem_to_reg,
                       mem_read:   held_q.mem_read,
                       rsvd:       2'b00,
                       wreg:       held_q.wreg,
                       wdata:      held_q.wdata,
                       result:     mul_product};
        end
      end
      default: ex_mem_d = EXMEM_BUBBLE;
    endcase
  end

  // ---------------- EX/MEM and held-control registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_mem_q <= EXMEM_BUBBLE;
      held_q   <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      held_q   <= held_d;
    end
  end

  assign EXMEMReg = ex_mem_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed pipeline cases plus randomized stream
// against a transaction-level reference model.
// Inputs driven on falling edge, outputs sampled 1 time unit after edges.
module tb_execute_stage;

  logic         clk;
  logic         rst_n;
  logic         inValid;
  logic [119:0] IDEXReg;
  logic         stall;
  logic [74:0]  EXMEMReg;

  int total = 0;
  int bad   = 0;

  execute_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .IDEXReg  (IDEXReg),
    .stall    (stall),
    .EXMEMReg (EXMEMReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [74:0] got, input logic [74:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] mk(input logic rw, input logic mtr, input logic mw,
                                      input logic mr, input logic [1:0] op, input logic rdst,
                                      input logic asrc, input logic [5:0] fn,
                                      input logic [4:0] rd, input logic [4:0] rt,
                                      input logic [31:0] imm, input logic [31:0] d2,
                                      input logic [31:0] d1);
    return {rw, mtr, mw, mr, op, rdst, asrc, fn, rd, rt, imm, d2, d1};
  endfunction

  function automatic logic is_mul_instr(input logic [119:0] w);
    return (w[115:114] == 2'b10) && (w[111:106] == 6'h18);
  endfunction

  // Reference: what EX/MEM must eventually hold for an instruction, from the ISA rules.
  function automatic logic [74:0] ref_exmem(input logic [119:0] w);
    logic [31:0] a, d2, b, res;
    logic [4:0]  wr;
    a   = w[31:0];
    d2  = w[63:32];
    b   = w[112] ? w[95:64] : d2;
    wr  = w[113] ? w[105:101] : w[100:96];
    res = 32'd0;
    case (w[115:114])
      2'b00, 2'b11: res = a + b;
      2'b01:        res = a - b;
      default: begin
        case (w[111:106])
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: res = a * d2;
          default: res = 32'd0;
        endcase
      end
    endcase
    return {w[119], w[117], w[118], w[116], 2'b00, wr, d2, res};
  endfunction

  // Present one word, follow stall until released, check bubbles, stall length and final word.
  task automatic run_instr(input string tag, input logic v, input logic [119:0] w);
    logic [74:0] exp;
    int n;
    int exp_n;
    exp   = v ? ref_exmem(w) : 75'd0;
    exp_n = (v && is_mul_instr(w)) ? 33 : 0;
    @(negedge clk);
    inValid = v;
    IDEXReg = w;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      check_eq({tag, "_bubble"}, EXMEMReg, 75'd0);
      n++;
      @(negedge clk); #1;
    end
    check_eq({tag, "_stall_cycles"}, 75'(n), 75'(exp_n));
    @(posedge clk); #1;
    check_eq(tag, EXMEMReg, exp);
  endtask

  logic [119:0] w;
  logic [31:0]  ra;

  initial begin
    rst_n   = 1'b0;
    inValid = 1'b0;
    IDEXReg = {$urandom, $urandom, $urandom, $urandom};

    // reset held for two edges
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("reset_exmem", EXMEMReg, 75'd0);
      check_eq("reset_stall", 75'(stall), 75'd0);
      @(negedge clk);
      IDEXReg = {$urandom, $urandom, $urandom, $urandom};
    end
    rst_n = 1'b1;

    // lw: 0x100 + 8 -> rt 5
    run_instr("lw", 1'b1, mk(1,1,0,1, 2'b00, 0, 1, 6'h00, 5'd9, 5'd5, 32'h8, 32'h55, 32'h100));
    check_eq("lw_result", 75'(EXMEMReg[31:0]), 75'h108);
    check_eq("lw_wreg", 75'(EXMEMReg[68:64]), 75'd5);
    check_eq("lw_ctrl", 75'(EXMEMReg[74:71]), 75'b1011);

    // R-type stream, rs=-2, rt=3
    run_instr("add", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h20, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("add_result", 75'(EXMEMReg[31:0]), 75'h1);
    run_instr("sub", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h22, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("sub_result", 75'(EXMEMReg[31:0]), 75'hFFFFFFFB);
    run_instr("and", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h24, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("and_result", 75'(EXMEMReg[31:0]), 75'h2);
    run_instr("or", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h25, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("or_result", 75'(EXMEMReg[31:0]), 75'hFFFFFFFF);
    run_instr("nor", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h27, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("nor_result", 75'(EXMEMReg[31:0]), 75'h0);
    run_instr("slt", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h2A, 5'd3, 5'd2, 32'h0, 32'h3, 32'hFFFFFFFE));
    check_eq("slt_result", 75'(EXMEMReg[31:0]), 75'h1);

    // sw
    run_instr("sw", 1'b1, mk(0,0,1,0, 2'b00, 0, 1, 6'h00, 5'd0, 5'd4, 32'h4, 32'hDEADBEEF, 32'h10));
    check_eq("sw_result", 75'(EXMEMReg[31:0]), 75'h14);
    check_eq("sw_wdata", 75'(EXMEMReg[63:32]), 75'hDEADBEEF);
    check_eq("sw_ctrl", 75'(EXMEMReg[74:71]), 75'b0100);

    // mul with follow-on add
    run_instr("mul", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h18, 5'd7, 5'd2, 32'h0, 32'h9ABCDEF0, 32'h12345678));
    check_eq("mul_result", 75'(EXMEMReg[31:0]), 75'h242D2080);
    check_eq("mul_wreg", 75'(EXMEMReg[68:64]), 75'd7);
    check_eq("mul_regwrite", 75'(EXMEMReg[74]), 75'd1);
    run_instr("add_after_mul", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h20, 5'd8, 5'd2, 32'h0, 32'd20, 32'd22));
    check_eq("add_after_mul_result", 75'(EXMEMReg[31:0]), 75'd42);

    // back-to-back multiplies
    run_instr("mul_3x5", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h18, 5'd9, 5'd1, 32'h0, 32'd5, 32'd3));
    check_eq("mul_3x5_result", 75'(EXMEMReg[31:0]), 75'd15);
    run_instr("mul_ff", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h18, 5'd10, 5'd1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF));
    check_eq("mul_ff_result", 75'(EXMEMReg[31:0]), 75'd1);

    // reset in the middle of a multiply (step counter at 10)
    @(negedge clk);
    inValid = 1'b1;
    IDEXReg = mk(1,0,0,0, 2'b10, 1, 0, 6'h18, 5'd11, 5'd1, 32'h0, 32'h1234, 32'hABCD);
    repeat (11) begin
      @(posedge clk); #1;
      check_eq("midrst_bubble", EXMEMReg, 75'd0);
    end
    check_eq("midrst_stall_before", 75'(stall), 75'd1);
    @(negedge clk);
    rst_n   = 1'b0;
    inValid = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_exmem", EXMEMReg, 75'd0);
    check_eq("midrst_stall", 75'(stall), 75'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("mul_6x7", 1'b1, mk(1,0,0,0, 2'b10, 1, 0, 6'h18, 5'd12, 5'd1, 32'h0, 32'd7, 32'd6));
    check_eq("mul_6x7_result", 75'(EXMEMReg[31:0]), 75'd42);

    // randomized stream
    for (int i = 0; i < 80; i++) begin
      int k;
      logic [5:0] fn;
      k = $urandom_range(0, 15);
      case (k)
        0, 1:   fn = 6'h20;
        2, 3:   fn = 6'h22;
        4, 5:   fn = 6'h24;
        6, 7:   fn = 6'h25;
        8, 9:   fn = 6'h27;
        10, 11: fn = 6'h2A;
        12:     fn = 6'h18;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      ra = $urandom;
      w  = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), fn, 5'($urandom), 5'($urandom),
              $urandom, $urandom, (k[0] ? ra : {28'd0, ra[3:0]}));
      run_instr("rand", ($urandom_range(0, 7) != 0), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
